// File: rtl/m3_pkg.sv
// Shared definitions for the m3 commutation step sequencer: state encoding,
// idle step marker, default parameter values and the step-advance helper.
package m3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } m3State_t;

  localparam logic [3:0] IDLE_STEP = 4'hF;

  localparam int STEP_N_DEF    = 12;
  localparam int LEN_W_DEF     = 22;
  localparam int CALC_STEP_DEF = 10;
  localparam int LEN_DELTA_DEF = 16;

  // Next step index with wrap in either direction; lastStep is STEP_N-1.
  function automatic logic [3:0] nextStep(input logic [3:0] cur,
                                          input logic       rev,
                                          input logic [3:0] lastStep);
    logic [3:0] res;
    if (rev) res = (cur == 4'd0) ? lastStep : cur - 4'd1;
    else     res = (cur == lastStep) ? 4'd0 : cur + 4'd1;
    return res;
  endfunction

endpackage

// File: rtl/m3_slice_timer.sv
// Loadable down-counter timing one commutation slice; tc flags the last
// cycle of the slice (count == 1). Clear parks the counter at all ones.
module m3_slice_timer #(
  parameter int LEN_W = 22
) (
  input  logic             clkI,
  input  logic             nRstI,
  input  logic             clear,
  input  logic             load,
  input  logic [LEN_W-1:0] loadVal,
  input  logic             en,
  output logic [LEN_W-1:0] count,
  output logic             tc
);

  logic [LEN_W-1:0] countReg;

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      countReg <= '1;
    end else if (clear) begin
      countReg <= '1;
    end else if (load) begin
      countReg <= loadVal;
    end else if (en) begin
      countReg <= countReg - LEN_W'(1);
    end
  end

  assign count = countReg;
  assign tc    = (countReg == LEN_W'(1));

endmodule

// File: rtl/m3_step_seq.sv
// Commutation step sequencer: walks STEP_N steps of curLen cycles each.
// Optional speed ramp is enabled by defining M3_SPEED_RAMP_EN.
module m3_step_seq
  import m3_pkg::*;
#(
  parameter int STEP_N    = STEP_N_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int CALC_STEP = CALC_STEP_DEF,
  parameter int LEN_DELTA = LEN_DELTA_DEF
) (
  input  logic             clkI,
  input  logic             nRstI,
  input  logic             startI,
  input  logic             forceStopI,
  input  logic             invRotateI,
  input  logic             speedIncI,
  input  logic             speedDecI,
  input  logic [LEN_W-1:0] sliceLenI,
  output logic [3:0]       stepO,
  output logic             workingO,
  output logic             nextCalc_1o,
  output logic             roundO,
  output logic [LEN_W-1:0] curLenO
);

  localparam logic [3:0]     LAST_STEP = 4'(STEP_N - 1);
  localparam logic [3:0]     CALC_IDX  = 4'(CALC_STEP);
  localparam logic [LEN_W:0] DELTA     = (LEN_W + 1)'(LEN_DELTA);

  m3State_t         stateReg, stateNext;
  logic [3:0]       stepReg, stepNext;
  logic [LEN_W-1:0] curLenReg, curLenNext;
  logic             roundReg, roundNext;
  logic             calcReg, calcNext;

  logic [LEN_W-1:0] sliceLenFloor;
  logic [LEN_W-1:0] boundaryLen;
  logic [3:0]       advStep;
  logic [3:0]       startStep;
  logic             isWrap;

  logic             timerClear, timerLoad, timerEn, timerTc;
  logic [LEN_W-1:0] remain;

  assign sliceLenFloor = (sliceLenI == '0) ? LEN_W'(1) : sliceLenI;
  assign advStep       = nextStep(stepReg, invRotateI, LAST_STEP);
  assign startStep     = invRotateI ? LAST_STEP : 4'd0;
  assign isWrap        = invRotateI ? (stepReg == 4'd0) : (stepReg == LAST_STEP);

`ifdef M3_SPEED_RAMP_EN
  logic             pendIncReg, pendDecReg;
  logic             effInc, effDec;
  logic [LEN_W:0]   curWide, sliceWide, adjWide;
  logic [LEN_W-1:0] rampLen;

  // A command arriving on the wrap cycle itself is honoured immediately.
  assign effInc = pendIncReg | speedIncI;
  assign effDec = pendDecReg | speedDecI;

  always_comb begin
    curWide   = {1'b0, curLenReg};
    sliceWide = {1'b0, sliceLenFloor};
    adjWide   = curWide;
    if (effInc && !effDec) begin
      adjWide = (curWide < (DELTA + DELTA)) ? DELTA : (curWide - DELTA);
    end else if (effDec && !effInc) begin
      adjWide = curWide + DELTA;
    end
    if ((effInc ^ effDec) && (adjWide > sliceWide)) begin
      adjWide = sliceWide;
    end
    rampLen = adjWide[LEN_W-1:0];
  end

  // Length only moves at the round wrap; other boundaries keep the current one.
  assign boundaryLen = isWrap ? rampLen : curLenReg;

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      pendIncReg <= 1'b0;
      pendDecReg <= 1'b0;
    end else if (stateReg == ST_IDLE || roundNext) begin
      pendIncReg <= 1'b0;
      pendDecReg <= 1'b0;
    end else begin
      pendIncReg <= pendIncReg | speedIncI;
      pendDecReg <= pendDecReg | speedDecI;
    end
  end
`else
  logic unusedSpeed;

  assign boundaryLen = sliceLenFloor;
  assign unusedSpeed = ^{speedIncI, speedDecI, DELTA};
`endif

  always_comb begin
    stateNext  = stateReg;
    stepNext   = stepReg;
    curLenNext = curLenReg;
    roundNext  = 1'b0;
    calcNext   = 1'b0;
    timerClear = 1'b0;
    timerLoad  = 1'b0;
    timerEn    = 1'b0;

    if (forceStopI) begin
      stateNext  = ST_IDLE;
      stepNext   = IDLE_STEP;
      timerClear = 1'b1;
    end else begin
      case (stateReg)
        ST_IDLE: begin
          if (startI) begin
            stateNext  = ST_RUN;
            stepNext   = startStep;
            curLenNext = sliceLenFloor;
            timerLoad  = 1'b1;
            calcNext   = (startStep == CALC_IDX);
          end
        end
        ST_RUN, ST_STOPPING: begin
          if (timerTc) begin
            if (startI) begin
              stateNext  = ST_RUN;
              stepNext   = advStep;
              curLenNext = boundaryLen;
              timerLoad  = 1'b1;
              roundNext  = isWrap;
              calcNext   = (advStep == CALC_IDX);
            end else begin
              stateNext  = ST_IDLE;
              stepNext   = IDLE_STEP;
              timerClear = 1'b1;
            end
          end else begin
            timerEn   = 1'b1;
            stateNext = startI ? ST_RUN : ST_STOPPING;
          end
        end
        default: begin
          stateNext  = ST_IDLE;
          stepNext   = IDLE_STEP;
          timerClear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      stateReg  <= ST_IDLE;
      stepReg   <= IDLE_STEP;
      curLenReg <= LEN_W'(1);
      roundReg  <= 1'b0;
      calcReg   <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      stepReg   <= stepNext;
      curLenReg <= curLenNext;
      roundReg  <= roundNext;
      calcReg   <= calcNext;
    end
  end

  // Every load coincides with a curLen update, so the reload value is curLenNext.
  m3_slice_timer #(
    .LEN_W(LEN_W)
  ) sliceTimer (
    .clkI   (clkI),
    .nRstI  (nRstI),
    .clear  (timerClear),
    .load   (timerLoad),
    .loadVal(curLenNext),
    .en     (timerEn),
    .count  (remain),
    .tc     (timerTc)
  );

  logic unusedRemain;
  assign unusedRemain = ^remain;

  assign stepO       = stepReg;
  assign workingO    = (stateReg != ST_IDLE);
  assign nextCalc_1o = calcReg;
  assign roundO      = roundReg;
  assign curLenO     = curLenReg;

endmodule
